time_counter_chain: RTL and testbench

- Parametrised successor to the cascaded msec/sec counter path.
- Single-clock prescaler plus a four-field time chain: centiseconds, seconds, minutes, hours.
- Supports run/stop, up/down mode, synchronous clear and load, rollover and countdown-done signalling.
- All fields advance on a clock-enable tick; no derived clocks. Field outputs feed the FND display controller.

---
 rtl/time_counter_chain.sv | 186 ++++++++++++++++++
 tb/tb_time_counter_chain.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter_chain.sv
// time_counter_chain: prescaler plus cascaded centisecond/second/minute/hour
// counter. Counts up (stopwatch) or down (timer) on a single clock using a
// clock-enable tick; flags rollover in up mode and reaching zero in down mode.
module time_counter_chain #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100,
    parameter int MSEC_MAX = 100,
    parameter int SEC_MAX  = 60,
    parameter int MIN_MAX  = 60,
    parameter int HOUR_MAX = 24,
    parameter int MW       = $clog2(MSEC_MAX),
    parameter int SW       = $clog2(SEC_MAX),
    parameter int NW       = $clog2(MIN_MAX),
    parameter int HW       = $clog2(HOUR_MAX)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_run,
    input  logic          i_clear,
    input  logic          i_mode,
    input  logic          i_load,
    input  logic [MW-1:0] i_load_msec,
    input  logic [SW-1:0] i_load_sec,
    input  logic [NW-1:0] i_load_min,
    input  logic [HW-1:0] i_load_hour,
    output logic [MW-1:0] o_msec,
    output logic [SW-1:0] o_sec,
    output logic [NW-1:0] o_min,
    output logic [HW-1:0] o_hour,
    output logic          o_tick,
    output logic          o_wrap,
    output logic          o_done,
    output logic          o_running
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [MW-1:0] MSEC_LAST  = MW'(MSEC_MAX - 1);
    localparam logic [SW-1:0] SEC_LAST   = SW'(SEC_MAX - 1);
    localparam logic [NW-1:0] MIN_LAST   = NW'(MIN_MAX - 1);
    localparam logic [HW-1:0] HOUR_LAST  = HW'(HOUR_MAX - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [MW-1:0] msec_q, msec_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [NW-1:0] min_q, min_d;
    logic [HW-1:0] hour_q, hour_d;
    logic          halted_q, halted_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          done_q, done_d;

    logic          running;
    logic          tick_en;
    logic          all_zero;

    assign running  = i_run & ~halted_q;
    assign tick_en  = running && (presc_q == PRESC_LAST);
    assign all_zero = (msec_q == '0) && (sec_q == '0) && (min_q == '0) && (hour_q == '0);

    // Next-state: clear beats load beats counting; fields move only on tick_en.
    always_comb begin
        presc_d  = presc_q;
        msec_d   = msec_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        halted_d = halted_q;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;
        done_d   = 1'b0;

        if (i_clear) begin
            presc_d  = '0;
            msec_d   = '0;
            sec_d    = '0;
            min_d    = '0;
            hour_d   = '0;
            halted_d = 1'b0;
        end else if (i_load) begin
            // Out-of-range load values saturate to the field's top value.
            presc_d  = '0;
            msec_d   = (i_load_msec > MSEC_LAST) ? MSEC_LAST : i_load_msec;
            sec_d    = (i_load_sec  > SEC_LAST)  ? SEC_LAST  : i_load_sec;
            min_d    = (i_load_min  > MIN_LAST)  ? MIN_LAST  : i_load_min;
            hour_d   = (i_load_hour > HOUR_LAST) ? HOUR_LAST : i_load_hour;
            halted_d = 1'b0;
        end else if (tick_en) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (!i_mode) begin
                // Up: each field carries into the next when it passes its top value.
                wrap_d = (msec_q == MSEC_LAST) && (sec_q == SEC_LAST) &&
                         (min_q == MIN_LAST) && (hour_q == HOUR_LAST);
                if (msec_q == MSEC_LAST) begin
                    msec_d = '0;
                    if (sec_q == SEC_LAST) begin
                        sec_d = '0;
                        if (min_q == MIN_LAST) begin
                            min_d = '0;
                            if (hour_q == HOUR_LAST) begin
                                hour_d = '0;
                            end else begin
                                hour_d = hour_q + 1'b1;
                            end
                        end else begin
                            min_d = min_q + 1'b1;
                        end
                    end else begin
                        sec_d = sec_q + 1'b1;
                    end
                end else begin
                    msec_d = msec_q + 1'b1;
                end
            end else if (all_zero) begin
                // Tick with nothing left to count: report done again and stop.
                done_d   = 1'b1;
                halted_d = 1'b1;
            end else begin
                // Down: each field borrows from the next when it passes zero.
                if (msec_q == '0) begin
                    msec_d = MSEC_LAST;
                    if (sec_q == '0) begin
                        sec_d = SEC_LAST;
                        if (min_q == '0) begin
                            min_d = MIN_LAST;
                            if (hour_q == '0) begin
                                hour_d = HOUR_LAST;
                            end else begin
                                hour_d = hour_q - 1'b1;
                            end
                        end else begin
                            min_d = min_q - 1'b1;
                        end
                    end else begin
                        sec_d = sec_q - 1'b1;
                    end
                end else begin
                    msec_d = msec_q - 1'b1;
                end
                done_d   = (msec_d == '0) && (sec_d == '0) && (min_d == '0) && (hour_d == '0);
                halted_d = done_d;
            end
        end else if (running) begin
            // Prescaler holds while stopped so a resume finishes the partial period.
            presc_d = presc_q + 1'b1;
        end
    end

    // State and pulse registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q  <= '0;
            msec_q   <= '0;
            sec_q    <= '0;
            min_q    <= '0;
            hour_q   <= '0;
            halted_q <= 1'b0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            msec_q   <= msec_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hour_q   <= hour_d;
            halted_q <= halted_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
            done_q   <= done_d;
        end
    end

    assign o_msec    = msec_q;
    assign o_sec     = sec_q;
    assign o_min     = min_q;
    assign o_hour    = hour_q;
    assign o_tick    = tick_q;
    assign o_wrap    = wrap_q;
    assign o_done    = done_q;
    assign o_running = running;

endmodule

// File: tb/tb_time_counter_chain.sv
// Bench for time_counter_chain: directed scenarios plus randomized traffic.
// The reference model keeps the time as a single centisecond total and
// derives the field values from it; expected tick results go to a queue
// that a separate monitor drains whenever the DUT pulses o_tick.
module tb_time_counter_chain;

    localparam int CLK_FREQ = 1000;
    localparam int TICK_HZ  = 100;
    localparam int DIV      = CLK_FREQ / TICK_HZ;
    localparam int MSEC_MAX = 100;
    localparam int SEC_MAX  = 60;
    localparam int MIN_MAX  = 60;
    localparam int HOUR_MAX = 24;
    localparam int MW = $clog2(MSEC_MAX);
    localparam int SW = $clog2(SEC_MAX);
    localparam int NW = $clog2(MIN_MAX);
    localparam int HW = $clog2(HOUR_MAX);
    localparam int FW = MW + SW + NW + HW;
    localparam int TOTAL = MSEC_MAX * SEC_MAX * MIN_MAX * HOUR_MAX;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_run = 1'b0;
    logic          i_clear = 1'b0;
    logic          i_mode = 1'b0;
    logic          i_load = 1'b0;
    logic [MW-1:0] i_load_msec = '0;
    logic [SW-1:0] i_load_sec = '0;
    logic [NW-1:0] i_load_min = '0;
    logic [HW-1:0] i_load_hour = '0;
    logic [MW-1:0] o_msec;
    logic [SW-1:0] o_sec;
    logic [NW-1:0] o_min;
    logic [HW-1:0] o_hour;
    logic          o_tick, o_wrap, o_done, o_running;

    time_counter_chain #(
        .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .MSEC_MAX(MSEC_MAX),
        .SEC_MAX(SEC_MAX), .MIN_MAX(MIN_MAX), .HOUR_MAX(HOUR_MAX)
    ) dut (
        .clk(clk), .reset(reset), .i_run(i_run), .i_clear(i_clear),
        .i_mode(i_mode), .i_load(i_load), .i_load_msec(i_load_msec),
        .i_load_sec(i_load_sec), .i_load_min(i_load_min), .i_load_hour(i_load_hour),
        .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
        .o_tick(o_tick), .o_wrap(o_wrap), .o_done(o_done), .o_running(o_running)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [FW-1:0] f;
        logic          wrap;
        logic          done;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model state: centisecond total, position within the tick period, halted flag.
    int   m_t = 0;
    int   m_ph = 0;
    bit   m_halt = 1'b0;

    function automatic logic [FW-1:0] pack(input int t);
        return {HW'(t / (MSEC_MAX * SEC_MAX * MIN_MAX)),
                NW'((t / (MSEC_MAX * SEC_MAX)) % MIN_MAX),
                SW'((t / MSEC_MAX) % SEC_MAX),
                MW'(t % MSEC_MAX)};
    endfunction

    function automatic int clampv(input int v, input int max);
        return (v > max - 1) ? max - 1 : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Apply the current inputs to the model for the coming edge, then let the edge happen.
    task automatic step();
        bit w;
        bit d;
        if (!reset) begin
            m_t = 0; m_ph = 0; m_halt = 1'b0;
        end else if (i_clear) begin
            m_t = 0; m_ph = 0; m_halt = 1'b0;
        end else if (i_load) begin
            m_t = ((clampv(int'(i_load_hour), HOUR_MAX) * MIN_MAX
                    + clampv(int'(i_load_min), MIN_MAX)) * SEC_MAX
                    + clampv(int'(i_load_sec), SEC_MAX)) * MSEC_MAX
                    + clampv(int'(i_load_msec), MSEC_MAX);
            m_ph = 0; m_halt = 1'b0;
        end else if (i_run && !m_halt) begin
            if (m_ph == DIV - 1) begin
                m_ph = 0;
                w = 1'b0;
                d = 1'b0;
                if (!i_mode) begin
                    w = (m_t == TOTAL - 1);
                    m_t = (m_t + 1) % TOTAL;
                end else if (m_t == 0) begin
                    d = 1'b1; m_halt = 1'b1;
                end else begin
                    m_t = m_t - 1;
                    if (m_t == 0) begin
                        d = 1'b1; m_halt = 1'b1;
                    end
                end
                sb.push_back('{cyc + 1, pack(m_t), w, d});
            end else begin
                m_ph++;
            end
        end
        @(negedge clk);
        chk("fields", 32'({o_hour, o_min, o_sec, o_msec}), 32'(pack(m_t)));
        chk("running", 32'(o_running), 32'(i_run && !m_halt));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic load_pulse(input int ms, input int s, input int m, input int h);
        i_load_msec = MW'(ms);
        i_load_sec  = SW'(s);
        i_load_min  = NW'(m);
        i_load_hour = HW'(h);
        i_load = 1'b1;
        step();
        i_load = 1'b0;
    endtask

    // Monitor: every tick pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (o_tick) begin
                if (sb.size() == 0) begin
                    chk("tick_unexpected", 32'(o_tick), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("tick_cycle", 32'(cyc), 32'(e.at));
                    chk("tick_fields", 32'({o_hour, o_min, o_sec, o_msec}), 32'(e.f));
                    chk("tick_wrap", 32'(o_wrap), 32'(e.wrap));
                    chk("tick_done", 32'(o_done), 32'(e.done));
                end
            end else begin
                chk("idle_pulses", 32'({o_wrap, o_done}), 32'd0);
                if (sb.size() > 0 && sb[0].at <= cyc) begin
                    e = sb.pop_front();
                    chk("tick_missing", 32'(o_tick), 32'd1);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int r;
        #1 reset = 1'b0;
        i_run = 1'b1;
        i_mode = 1'b0;
        @(negedge clk);
        // Outputs held at zero throughout reset.
        chk("rst_fields", 32'({o_hour, o_min, o_sec, o_msec}), 32'd0);
        chk("rst_pulses", 32'({o_tick, o_wrap, o_done}), 32'd0);
        steps(3);
        chk("rst_pulses2", 32'({o_tick, o_wrap, o_done}), 32'd0);

        // Release: first field step after one full period, then another.
        reset = 1'b1;
        steps(2 * DIV + 2);

        // Full rollover from the top of the range.
        load_pulse(99, 59, 59, 23);
        steps(DIV + 2);

        // Countdown to zero, then halted through i_run toggles.
        i_mode = 1'b1;
        load_pulse(0, 1, 0, 0);
        steps(DIV);
        chk("down_first", 32'({o_hour, o_min, o_sec, o_msec}), 32'(pack(99)));
        steps(99 * DIV);
        chk("down_zero_run", 32'(o_running), 32'd0);
        for (int k = 0; k < 50 * DIV; k++) begin
            if (k % 37 == 0) i_run = ~i_run;
            step();
        end
        i_run = 1'b1;
        step();
        chk("halt_sticky", 32'(o_running), 32'd0);

        // Pause mid-period: resume finishes the remaining part.
        i_mode = 1'b0;
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        steps(5);
        i_run = 1'b0;
        steps(20);
        i_run = 1'b1;
        steps(DIV + 2);

        // Clear outranks load; loads saturate.
        i_clear = 1'b1;
        load_pulse(50, 30, 0, 0);
        i_clear = 1'b0;
        chk("clr_over_load", 32'({o_hour, o_min, o_sec, o_msec}), 32'd0);
        i_run = 1'b0;
        load_pulse(120, 63, 0, 0);
        chk("clamp_msec", 32'(o_msec), 32'd99);
        chk("clamp_sec", 32'(o_sec), 32'd59);

        // Asynchronous reset in the middle of a period.
        i_run = 1'b1;
        load_pulse(12, 34, 5, 6);
        steps(4);
        #1 reset = 1'b0;
        #1;
        chk("async_fields", 32'({o_hour, o_min, o_sec, o_msec}), 32'd0);
        chk("async_pulses", 32'({o_tick, o_wrap, o_done}), 32'd0);
        m_t = 0; m_ph = 0; m_halt = 1'b0;
        steps(2);
        reset = 1'b1;
        steps(DIV + 2);

        // Randomized traffic biased toward rollover and countdown boundaries.
        for (int k = 0; k < 4000; k++) begin
            i_clear = 1'b0;
            i_load = 1'b0;
            i_run = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 199) == 0) i_mode = ~i_mode;
            if ($urandom_range(0, 499) == 0) i_clear = 1'b1;
            if ($urandom_range(0, 149) == 0) begin
                r = $urandom_range(0, 2);
                i_load = 1'b1;
                if (r == 0) begin
                    i_load_msec = MW'(99 - $urandom_range(0, 20));
                    i_load_sec = 6'd59; i_load_min = 6'd59; i_load_hour = 5'd23;
                end else if (r == 1) begin
                    i_load_msec = MW'($urandom_range(0, 20));
                    i_load_sec = '0; i_load_min = '0; i_load_hour = '0;
                end else begin
                    i_load_msec = MW'($urandom);
                    i_load_sec = SW'($urandom);
                    i_load_min = NW'($urandom);
                    i_load_hour = HW'($urandom);
                end
            end
            step();
        end
        i_clear = 1'b0;
        i_load = 1'b0;
        i_run = 1'b0;
        steps(3);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
